// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants and helpers for the writeback-port arbiter.
//   N_REQ_DEF / DATA_WIDTH_DEF : default requester count and payload width
//   ptr_w()                    : width of the round-robin pointer
//   oh2idx()                   : one-hot vector to binary index
// -----------------------------------------------------------------------------
package arb_pkg;

   localparam int N_REQ_DEF      = 4;
   localparam int DATA_WIDTH_DEF = 32;

   // Pointer width; kept at least 1 bit so the pointer is never zero-width.
   function automatic int ptr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Callers zero-extend into 64 bits. Input is one-hot or zero; zero maps to 0.
   function automatic int oh2idx(input logic [63:0] oh);
      int r;
      r = 0;
      for (int i = 0; i < 64; i++)
         if (oh[i]) r = i;
      return r;
   endfunction

endpackage

// File: rtl/onehot_mux.sv
// -----------------------------------------------------------------------------
// onehot_mux
// Parameterised AND-OR mux steered by a one-hot (or all-zero) select.
// An all-zero select produces all-zero data.
//   sel   in  N       one-hot select
//   data  in  N*W     packed inputs, input i at [i*W +: W]
//   out   out W       selected input
// -----------------------------------------------------------------------------
module onehot_mux #(
   parameter int N = 4,
   parameter int W = 32
) (
   input  logic [N-1:0]   sel,
   input  logic [N*W-1:0] data,
   output logic [W-1:0]   out
);

   always_comb begin
      out = '0;
      for (int i = 0; i < N; i++)
         out = out | (data[i*W +: W] & {W{sel[i]}});
   end

endmodule

// File: rtl/wb_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin pick: the first set bit of req, scanning
// ptr, ptr+1, ... and wrapping modulo N_REQ.
//   req   in  N_REQ  request vector
//   ptr   in  PW     highest-priority index (0..N_REQ-1)
//   pick  out N_REQ  one-hot pick, zero when req is zero
// -----------------------------------------------------------------------------
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PW    = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] pick
);

   int   idx;
   logic found;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Round-robin arbiter sharing one writeback port among N_REQ producers.
// The winner's payload is captured in a single output register; the
// consumer drains it with out_valid/out_ready. Full throughput: a new
// payload is accepted in the same cycle the old one is consumed.
//   clk           in   clock
//   rst           in   synchronous active-high reset
//   flush         in   drop output stage contents, block acceptance this cycle
//   req_valid     in   N_REQ            per-requester valid
//   req_data      in   N_REQ*DATA_WIDTH packed payloads
//   req_ready     out  N_REQ            one-hot acceptance (combinational)
//   grant_onehot  out  N_REQ            shared-mux select, equals req_ready
//   out_valid     out  output stage holds a payload
//   out_data      out  DATA_WIDTH       registered payload
//   out_src       out  N_REQ            one-hot producer id of out_data
//   out_ready     in   consumer accepts out_data
// -----------------------------------------------------------------------------
module wb_port_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ      = N_REQ_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            req_ready,
   output logic [N_REQ-1:0]            grant_onehot,
   output logic                        out_valid,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic [N_REQ-1:0]            out_src,
   input  logic                        out_ready
);

   localparam int PW = ptr_w(N_REQ);

   logic [PW-1:0]         ptr;
   logic [PW-1:0]         next_ptr;
   logic [N_REQ-1:0]      pick;
   logic [N_REQ-1:0]      grant;
   logic [DATA_WIDTH-1:0] mux_data;
   logic                  can_accept;
   logic                  fire;
   int                    win_idx;

   // Output slot is free, or being emptied this cycle; flush blocks refill.
   assign can_accept = (!out_valid || out_ready) && !flush;

   rr_pick #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) u_pick (
      .req  (req_valid),
      .ptr  (ptr),
      .pick (pick)
   );

   assign grant        = can_accept ? pick : '0;
   assign grant_onehot = grant;
   assign req_ready    = grant;
   assign fire         = |grant;

   onehot_mux #(
      .N (N_REQ),
      .W (DATA_WIDTH)
   ) u_mux (
      .sel  (grant),
      .data (req_data),
      .out  (mux_data)
   );

   // Pointer moves to the slot just after the winner.
   always_comb begin
      win_idx  = oh2idx(64'(grant));
      next_ptr = (win_idx == N_REQ - 1) ? '0 : PW'(win_idx + 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
         ptr       <= '0;
      end else if (fire) begin
         out_valid <= 1'b1;
         out_data  <= mux_data;
         out_src   <= grant;
         ptr       <= next_ptr;
      end else if (flush || out_ready) begin
         // Drain or flush: data/src keep their stale values.
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

   localparam int N = 4;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst;
   logic           flush;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant_onehot;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [N-1:0]   out_src;
   logic           out_ready;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int           m_ptr;
   bit           m_valid;
   logic [W-1:0] m_data;
   logic [N-1:0] m_src;

   always #5 clk = ~clk;

   wb_port_arbiter #(.N_REQ(N), .DATA_WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .grant_onehot (grant_onehot),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_src      (out_src),
      .out_ready    (out_ready)
   );

   // Winner = valid requester at the smallest cyclic distance from the pointer.
   function automatic logic [N-1:0] m_grant();
      int best, bestd, d;
      logic [N-1:0] g;
      g = '0;
      if (flush || (m_valid && !out_ready)) return g;
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
         d = (i - m_ptr + N) % N;
         if (req_valid[i] && d < bestd) begin
            bestd = d;
            best  = i;
         end
      end
      if (best >= 0) g[best] = 1'b1;
      return g;
   endfunction

   function automatic logic [W-1:0] slot(input int i);
      return req_data[i*W +: W];
   endfunction

   // Advance one clock and update the model with the inputs seen at that edge.
   task automatic tick();
      logic [N-1:0] g;
      int w;
      g = m_grant();
      w = -1;
      for (int i = 0; i < N; i++) if (g[i]) w = i;
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_data = '0; m_src = '0; m_ptr = 0;
      end else if (w >= 0) begin
         m_valid = 1; m_data = slot(w); m_src = g; m_ptr = (w + 1) % N;
      end else if (flush || out_ready) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic set_data_a0();
      for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'h000000A0 + i;
   endtask

   task automatic test_reset();
      rst = 1; flush = 0; req_valid = '0; out_ready = 0; req_data = '0;
      tick(); tick();
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b data=%h src=%b want 0/0/0", out_valid, out_data, out_src);
      end
      rst = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (req_ready !== '0) begin
            n_fail++; $display("FAIL idle_ready c%0d: got %b want 0000", c, req_ready);
         end
         tick();
         n_tests++;
         if (out_valid !== 1'b0 || out_data !== '0 || out_src !== '0) begin
            n_fail++;
            $display("FAIL idle_out c%0d: valid=%b data=%h src=%b want 0", c, out_valid, out_data, out_src);
         end
      end
   endtask

   task automatic test_rotation();
      logic [N-1:0] exp_oh;
      req_valid = '1; out_ready = 1; set_data_a0();
      for (int c = 0; c < 8; c++) begin
         exp_oh = '0; exp_oh[c % N] = 1'b1;
         #1;
         n_tests++;
         if (req_ready !== exp_oh || grant_onehot !== m_grant()) begin
            n_fail++;
            $display("FAIL rot_grant c%0d: got %b want %b", c, req_ready, exp_oh);
         end
         tick();
         n_tests++;
         if (out_valid !== 1'b1 || out_src !== exp_oh || out_data !== 32'h000000A0 + (c % N)) begin
            n_fail++;
            $display("FAIL rot_out c%0d: src=%b data=%h want %b %h", c, out_src, out_data, exp_oh, 32'h000000A0 + (c % N));
         end
      end
   endtask

   task automatic test_stall();
      // pointer is 0 after two full rotations
      req_valid = 4'b0010; req_data[1*W +: W] = 32'h0000FF00; out_ready = 1;
      tick();
      req_valid = '1; out_ready = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_tests++;
         if (req_ready !== '0) begin
            n_fail++; $display("FAIL stall_ready c%0d: got %b want 0000", c, req_ready);
         end
         tick();
         n_tests++;
         if (out_valid !== 1'b1 || out_data !== 32'h0000FF00 || out_src !== 4'b0010) begin
            n_fail++;
            $display("FAIL stall_hold c%0d: valid=%b data=%h src=%b want 1 0000ff00 0010", c, out_valid, out_data, out_src);
         end
      end
      out_ready = 1;
      #1;
      n_tests++;
      if (req_ready !== 4'b0100) begin
         n_fail++; $display("FAIL stall_release_grant: got %b want 0100", req_ready);
      end
      tick();
      n_tests++;
      if (out_data !== slot(2) || out_src !== 4'b0100) begin
         n_fail++; $display("FAIL stall_release_out: data=%h src=%b want %h 0100", out_data, out_src, slot(2));
      end
   endtask

   task automatic test_single_wrap();
      req_valid = 4'b1000; out_ready = 1;
      for (int c = 0; c < 5; c++) begin
         req_data[3*W +: W] = $urandom;
         #1;
         n_tests++;
         if (grant_onehot !== 4'b1000) begin
            n_fail++; $display("FAIL single_grant c%0d: got %b want 1000", c, grant_onehot);
         end
         tick();
         n_tests++;
         if (out_valid !== 1'b1 || out_data !== m_data || out_src !== 4'b1000) begin
            n_fail++; $display("FAIL single_out c%0d: data=%h src=%b want %h 1000", c, out_data, out_src, m_data);
         end
      end
      req_valid = 4'b1001;
      #1;
      n_tests++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL wrap_grant: got %b want 0001", req_ready);
      end
      tick();
   endtask

   task automatic test_flush();
      req_valid = 4'b0010; out_ready = 1; set_data_a0();
      tick();
      flush = 1;
      #1;
      n_tests++;
      if (req_ready !== '0 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL flush_ready: ready=%b valid=%b want 0000 1", req_ready, out_valid);
      end
      tick();
      flush = 0;
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL flush_drop: valid=%b want 0", out_valid);
      end
      #1;
      n_tests++;
      if (req_ready !== 4'b0010) begin
         n_fail++; $display("FAIL flush_after_grant: got %b want 0010", req_ready);
      end
      tick();
      n_tests++;
      if (out_src !== 4'b0010 || out_data !== 32'h000000A1) begin
         n_fail++; $display("FAIL flush_after_out: src=%b data=%h want 0010 a1", out_src, out_data);
      end
   endtask

   task automatic test_mid_reset();
      req_valid = '1; out_ready = 1;
      tick(); tick(); tick();
      rst = 1;
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || out_src !== '0) begin
         n_fail++; $display("FAIL midrst_out: valid=%b src=%b want 0 0000", out_valid, out_src);
      end
      rst = 0;
      #1;
      n_tests++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL midrst_grant: got %b want 0001", req_ready);
      end
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] g;
      for (int c = 0; c < 400; c++) begin
         req_valid = N'($urandom);
         for (int i = 0; i < N; i++) req_data[i*W +: W] = $urandom;
         out_ready = ($urandom_range(9, 0) < 7);
         flush     = ($urandom_range(19, 0) == 0);
         #1;
         g = m_grant();
         n_tests++;
         if (req_ready !== g || grant_onehot !== g || !$onehot0(req_ready)) begin
            n_fail++; $display("FAIL rand_grant c%0d: ready=%b grant=%b want %b", c, req_ready, grant_onehot, g);
         end
         tick();
         n_tests++;
         if (out_valid !== m_valid || (m_valid && (out_data !== m_data || out_src !== m_src))) begin
            n_fail++;
            $display("FAIL rand_out c%0d: v=%b d=%h s=%b want %b %h %b", c, out_valid, out_data, out_src, m_valid, m_data, m_src);
         end
      end
      flush = 0;
   endtask

   initial begin
      m_ptr = 0; m_valid = 0; m_data = '0; m_src = '0;
      test_reset();
      test_rotation();
      test_stall();
      test_single_wrap();
      test_flush();
      test_mid_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
